// File: rtl/fc_in_buffer.sv
// fc_in_buffer: serial-to-parallel activation buffer for the FC layer.
// Optional ping-pong banks: define FC_IN_DBUF_EN.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_s_valid/o_s_ready     stream element handshake
//   i_s_data, i_s_last      element value, end-of-frame marker
//   o_x, o_x_valid          assembled vector and its valid flag
//   i_x_ready               consumer accepts o_x this cycle
//   o_fill_cnt              elements written into the fill bank
//   o_err                   sticky frame-length error
module fc_in_buffer #(
    parameter int WIDTH = 8,
    parameter int IN    = 400,
    localparam int CNTW = $clog2(IN + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_s_valid,
    output logic                        o_s_ready,
    input  logic [WIDTH-1:0]            i_s_data,
    input  logic                        i_s_last,
    output logic [IN-1:0][WIDTH-1:0]    o_x,
    output logic                        o_x_valid,
    input  logic                        i_x_ready,
    output logic [CNTW-1:0]             o_fill_cnt,
    output logic                        o_err
);

    localparam logic [CNTW-1:0] LAST = CNTW'(IN - 1);

    logic [CNTW-1:0] r_fill_cnt;
    logic            r_err;
    logic            w_acc;
    logic            w_end;
    logic            w_early;
    logic            w_pres;

    assign w_acc   = i_s_valid & o_s_ready;
    assign w_end   = w_acc & (r_fill_cnt == LAST);
    assign w_early = w_acc & i_s_last & (r_fill_cnt != LAST);
    assign w_pres  = o_x_valid & i_x_ready;

    assign o_fill_cnt = r_fill_cnt;
    assign o_err      = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_end || w_early) begin
                r_fill_cnt <= '0;
            end else if (w_acc) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            // early s_last, or a full frame without s_last
            if (w_early || (w_end && !i_s_last)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FC_IN_DBUF_EN

    logic [IN-1:0][WIDTH-1:0] r_bank [2];
    logic                     r_sel;
    logic                     r_pvalid;
    logic                     r_ffull;

    // r_sel is the fill bank; the other one is presented
    assign o_s_ready = !i_rst && !r_ffull;
    assign o_x_valid = r_pvalid;
    assign o_x       = r_bank[~r_sel];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                r_bank[b] <= '0;
            end
            r_sel    <= 1'b0;
            r_pvalid <= 1'b0;
            r_ffull  <= 1'b0;
        end else begin
            if (w_acc && !w_early) begin
                r_bank[r_sel][r_fill_cnt] <= i_s_data;
            end
            if (w_end) begin
                // r_ffull is 0 here since s_ready gated the accept
                if (!r_pvalid || w_pres) begin
                    r_sel    <= ~r_sel;
                    r_pvalid <= 1'b1;
                end else begin
                    r_ffull <= 1'b1;
                end
            end else if (w_pres) begin
                if (r_ffull) begin
                    r_sel   <= ~r_sel;
                    r_ffull <= 1'b0;
                end else begin
                    r_pvalid <= 1'b0;
                end
            end
        end
    end

`else

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]               r_state;
    logic [IN-1:0][WIDTH-1:0] r_bank;

    assign o_s_ready = !i_rst && (r_state == S_FILL);
    assign o_x_valid = (r_state == S_FULL);
    assign o_x       = r_bank;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FILL;
            r_bank  <= '0;
        end else begin
            // accepts only happen in FILL, so x is frozen in FULL
            if (w_acc && !w_early) begin
                r_bank[r_fill_cnt] <= i_s_data;
            end
            case (r_state)
                S_FILL: if (w_end) r_state <= S_FULL;
                S_FULL: if (w_pres) r_state <= S_FILL;
                default: r_state <= S_FILL;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_fc_in_buffer.sv
// tb_fc_in_buffer: directed self-checking bench for fc_in_buffer.
// Covers reset, framing, hold, errors and (with FC_IN_DBUF_EN) ping-pong.
module tb_fc_in_buffer;

    localparam int W = 8;
    localparam int N = 400;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_last = 1'b0;
    logic                x_ready = 1'b0;
    logic [W-1:0]        s_data = '0;
    logic                s_ready;
    logic                x_valid;
    logic                err;
    logic [N-1:0][W-1:0] x;
    logic [8:0]          fill_cnt;
    logic [N-1:0][W-1:0] saved;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;

    always #5 clk = ~clk;

    fc_in_buffer #(.WIDTH(W), .IN(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .i_s_data   (s_data),
        .i_s_last   (s_last),
        .o_x        (x),
        .o_x_valid  (x_valid),
        .i_x_ready  (x_ready),
        .o_fill_cnt (fill_cnt),
        .o_err      (err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && g < 1000) begin
            stalls++;
            tick();
            g++;
        end
        if (!s_ready) check("send_timeout", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic present();
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_ready", 32'(s_ready), 0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(s_ready), 1);
        check("rst_cnt", 32'(fill_cnt), 0);
        check("rst_valid", 32'(x_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_x", 32'(x == '0), 1);

        for (int i = 0; i < N - 1; i++) send(W'(i), 1'b0);
        check("pre_valid", 32'(x_valid), 0);
        check("cnt_399", 32'(fill_cnt), 399);
        send(W'(N - 1), 1'b1);
        check("f1_valid", 32'(x_valid), 1);
        check("f1_x0", 32'(x[0]), 0);
        check("f1_x255", 32'(x[255]), 255);
        check("f1_x399", 32'(x[399]), 143);
        check("f1_cnt", 32'(fill_cnt), 0);
        check("f1_err", 32'(err), 0);

`ifdef FC_IN_DBUF_EN
        check("a_ready", 32'(s_ready), 1);
        stalls = 0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) x_ready = 1'b1;
            send(W'(i) ^ 8'hFF, i == N - 1);
            x_ready = 1'b0;
            if (i == 200) check("a_stable", 32'(x[5]), 5);
        end
        check("b_nostall", 32'(stalls), 0);
        check("b_valid", 32'(x_valid), 1);
        check("b_x0", 32'(x[0]), 32'h0FF);
        check("b_x399", 32'(x[399]), 32'h070);
        check("b_ready", 32'(s_ready), 1);
        for (int i = 0; i < N; i++) send(8'h11, i == N - 1);
        check("c_ready", 32'(s_ready), 0);
        check("c_hold", 32'(x[0]), 32'h0FF);
        check("c_valid", 32'(x_valid), 1);
        present();
        check("c_x0", 32'(x[0]), 32'h011);
        check("c_valid2", 32'(x_valid), 1);
        check("c_ready2", 32'(s_ready), 1);
        present();
        check("c_done", 32'(x_valid), 0);
`else
        check("f1_ready", 32'(s_ready), 0);
        saved = x;
        for (int i = 0; i < 50; i++) begin
            s_valid = i[0];
            s_data  = W'($urandom);
            tick();
        end
        s_valid = 1'b0;
        check("hold_x", 32'(x == saved), 1);
        check("hold_cnt", 32'(fill_cnt), 0);
        check("hold_valid", 32'(x_valid), 1);
        present();
        check("pres_valid", 32'(x_valid), 0);
        check("pres_ready", 32'(s_ready), 1);

        for (int i = 0; i < 10; i++) send(8'h5A, i == 9);
        check("early_err", 32'(err), 1);
        check("early_cnt", 32'(fill_cnt), 0);
        check("early_valid", 32'(x_valid), 0);
        for (int i = 0; i < N; i++) send(W'(i * 3), i == N - 1);
        check("f2_valid", 32'(x_valid), 1);
        check("f2_x1", 32'(x[1]), 3);
        check("f2_x399", 32'(x[399]), 173);
        check("f2_err", 32'(err), 1);
        present();

        pulse_rst();
        check("err_clr", 32'(err), 0);
        for (int i = 0; i < N; i++) send(8'h55, 1'b0);
        check("nolast_err", 32'(err), 1);
        check("nolast_valid", 32'(x_valid), 1);
        check("nolast_x7", 32'(x[7]), 32'h55);
`endif

        pulse_rst();
        check("r2_err", 32'(err), 0);
        check("r2_valid", 32'(x_valid), 0);
        check("r2_x", 32'(x == '0), 1);

        for (int i = 0; i < 200; i++) send(8'h33, 1'b0);
        check("mid_cnt", 32'(fill_cnt), 200);
        rst = 1'b1;
        tick();
        check("mid_rst_cnt", 32'(fill_cnt), 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            send((i == 0) ? 8'hAA : 8'h00, i == N - 1);
        end
        check("aa_valid", 32'(x_valid), 1);
        check("aa_x0", 32'(x[0]), 32'h0AA);
        check("aa_rest", 32'(x[N-1:1] == '0), 1);
        check("aa_err", 32'(err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
